// File: rtl/pe_col_feeder_if.sv
// Ifmap pixel stream handshake between the pixel producer and the column feeder.
// The master side drives pixels and the downstream stall; the slave side returns ready.
interface pe_col_feeder_if;
    localparam int unsigned PIX_W = 24;

    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] s_data;
    logic             col_hold;

    modport master (output s_valid, output s_data, output col_hold, input s_ready);
    modport slave  (input s_valid, input s_data, input col_hold, output s_ready);
endinterface

// File: rtl/pe_col_feeder.sv
// Line-buffered ifmap feeder for a 3-PE convolution column: presents rows r-2/r-1/r per column.
// Optional define PE_FEED_ZERO_PAD_EN: pe_en also fires in rows 0/1 with the missing rows forced to 0.
module pe_col_feeder #(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8,
    parameter int unsigned CW    = 3
) (
    input  logic                  PE_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  flt_wr,
    input  logic [1:0]            flt_row,
    input  logic [11:0]           flt_data,
    pe_col_feeder_if.slave        s,
    output logic [23:0]           Ifmap_feed_1,
    output logic [23:0]           Ifmap_feed_2,
    output logic [23:0]           Ifmap_feed_3,
    output logic [11:0]           Filtr_feed_1,
    output logic [11:0]           Filtr_feed_2,
    output logic [11:0]           Filtr_feed_3,
    output logic                  pe_en,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int unsigned PW = 24;
    localparam int unsigned FW = 12;
    localparam int unsigned AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e         state_q;
    logic [CW-1:0]  col_q;
    logic [CW-1:0]  row_q;
    logic [PW-1:0]  feed1_q, feed2_q, feed3_q;
    logic [FW-1:0]  flt1_q, flt2_q, flt3_q;
    logic           pe_en_q;
    logic           busy_q;
    logic           frame_done_q;

    logic [PW-1:0]  lb1 [IMG_W];
    logic [PW-1:0]  lb2 [IMG_W];

    logic           accept_c;
    logic           last_col_c;
    logic [AW-1:0]  idx_c;

    // Ready depends only on state and stall, never on s_valid.
    assign s.s_ready  = ((state_q == FILL) || (state_q == STREAM)) && !s.col_hold;
    assign accept_c   = s.s_valid && s.s_ready;
    assign last_col_c = (col_q == CW'(IMG_W - 1));
    assign idx_c      = AW'(col_q);

    // Line buffers shift one row down per accepted pixel; contents survive reset.
    always_ff @(posedge PE_clk) begin
        if (rst_n && accept_c) begin
            lb2[idx_c] <= lb1[idx_c];
            lb1[idx_c] <= s.s_data;
        end
    end

    always_ff @(posedge PE_clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            feed1_q      <= '0;
            feed2_q      <= '0;
            feed3_q      <= '0;
            flt1_q       <= '0;
            flt2_q       <= '0;
            flt3_q       <= '0;
            pe_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            pe_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (flt_wr) begin
                        case (flt_row)
                            2'd0:    flt1_q <= flt_data;
                            2'd1:    flt2_q <= flt_data;
                            2'd2:    flt3_q <= flt_data;
                            default: ;
                        endcase
                    end
                    if (start) begin
                        state_q <= FILL;
                        col_q   <= '0;
                        row_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                FILL, STREAM: begin
                    if (accept_c) begin
`ifdef PE_FEED_ZERO_PAD_EN
                        feed1_q <= (row_q < CW'(2)) ? '0 : lb2[idx_c];
                        feed2_q <= (row_q == '0)    ? '0 : lb1[idx_c];
                        pe_en_q <= 1'b1;
`else
                        feed1_q <= lb2[idx_c];
                        feed2_q <= lb1[idx_c];
                        pe_en_q <= (state_q == STREAM);
`endif
                        feed3_q <= s.s_data;
                        if (last_col_c) begin
                            col_q <= '0;
                            row_q <= row_q + CW'(1);
                            if ((state_q == FILL) && (row_q == CW'(1))) begin
                                state_q <= STREAM;
                            end
                            if ((state_q == STREAM) && (row_q == CW'(IMG_H - 1))) begin
                                state_q <= DONE;
                            end
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                DONE: begin
                    frame_done_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Ifmap_feed_1 = feed1_q;
    assign Ifmap_feed_2 = feed2_q;
    assign Ifmap_feed_3 = feed3_q;
    assign Filtr_feed_1 = flt1_q;
    assign Filtr_feed_2 = flt2_q;
    assign Filtr_feed_3 = flt3_q;
    assign pe_en        = pe_en_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
endmodule

// File: tb/tb_pe_col_feeder.sv
// Bench for pe_col_feeder on a 4x3 image: image-array reference model plus literal frame checks.
// Define PE_FEED_ZERO_PAD_EN for both bench and RTL to exercise the zero-pad build.
module tb_pe_col_feeder;
    localparam int unsigned W = 4;
    localparam int unsigned H = 3;
`ifdef PE_FEED_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic        PE_clk   = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic        flt_wr   = 1'b0;
    logic [1:0]  flt_row  = 2'd0;
    logic [11:0] flt_data = 12'h0;
    logic [23:0] Ifmap_feed_1, Ifmap_feed_2, Ifmap_feed_3;
    logic [11:0] Filtr_feed_1, Filtr_feed_2, Filtr_feed_3;
    logic        pe_en, busy, frame_done;

    pe_col_feeder_if ifc ();

    pe_col_feeder #(.IMG_W(W), .IMG_H(H), .CW(3)) dut (
        .PE_clk      (PE_clk),
        .rst_n       (rst_n),
        .start       (start),
        .flt_wr      (flt_wr),
        .flt_row     (flt_row),
        .flt_data    (flt_data),
        .s           (ifc.slave),
        .Ifmap_feed_1(Ifmap_feed_1),
        .Ifmap_feed_2(Ifmap_feed_2),
        .Ifmap_feed_3(Ifmap_feed_3),
        .Filtr_feed_1(Filtr_feed_1),
        .Filtr_feed_2(Filtr_feed_2),
        .Filtr_feed_3(Filtr_feed_3),
        .pe_en       (pe_en),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 PE_clk = ~PE_clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole image kept as a 2-D array, feeds derived from row/column arithmetic.
    int          m_phase = 0;   // 0 idle, 1 in frame, 2 frame-complete cycle
    int          m_k     = 0;
    logic [23:0] img [H][W];
    logic [23:0] e_f1 = '0, e_f2 = '0, e_f3 = '0;
    bit          k1 = 1'b0, k2 = 1'b0, k3 = 1'b0;
    logic [11:0] e_g [3];
    bit          e_pe = 1'b0, e_fd = 1'b0, e_busy = 1'b0;

    always @(posedge PE_clk) begin
        int r, c;
        if (!rst_n) begin
            m_phase = 0; m_k = 0;
            e_f1 = '0; e_f2 = '0; e_f3 = '0; k1 = 1; k2 = 1; k3 = 1;
            for (int i = 0; i < 3; i++) e_g[i] = '0;
            e_pe = 0; e_fd = 0; e_busy = 0;
        end else begin
            e_pe = 0; e_fd = 0;
            if (m_phase == 0) begin
                if (flt_wr && flt_row != 2'd3) e_g[int'(flt_row)] = flt_data;
                if (start) begin m_phase = 1; m_k = 0; e_busy = 1; end
            end else if (m_phase == 1) begin
                if (ifc.s_valid && !ifc.col_hold) begin
                    r = m_k / W; c = m_k % W;
                    img[r][c] = ifc.s_data;
                    e_f3 = ifc.s_data; k3 = 1;
                    if (r >= 1) begin e_f2 = img[r-1][c]; k2 = 1; end
                    else begin e_f2 = '0; k2 = PAD; end
                    if (r >= 2) begin e_f1 = img[r-2][c]; k1 = 1; end
                    else begin e_f1 = '0; k1 = PAD; end
                    e_pe = (r >= 2) || PAD;
                    m_k++;
                    if (m_k == W * H) m_phase = 2;
                end
            end else begin
                e_fd = 1; e_busy = 0; m_phase = 0;
            end
        end
    end

    bit          chk_en = 1'b0;
    int          cyc = 0, last_pe_cyc = 0, fd_gap = -1;
    int          pe_cnt = 0, fd_cnt = 0;
    logic [71:0] trip_q [$];

    always @(negedge PE_clk) begin
        if (chk_en) begin
            cyc++;
            check("s_ready", 32'(ifc.s_ready), 32'((m_phase == 1) && !ifc.col_hold));
            check("pe_en", 32'(pe_en), 32'(e_pe));
            check("frame_done", 32'(frame_done), 32'(e_fd));
            check("busy", 32'(busy), 32'(e_busy));
            check("Filtr_feed_1", 32'(Filtr_feed_1), 32'(e_g[0]));
            check("Filtr_feed_2", 32'(Filtr_feed_2), 32'(e_g[1]));
            check("Filtr_feed_3", 32'(Filtr_feed_3), 32'(e_g[2]));
            if (k1) check("Ifmap_feed_1", 32'(Ifmap_feed_1), 32'(e_f1));
            if (k2) check("Ifmap_feed_2", 32'(Ifmap_feed_2), 32'(e_f2));
            if (k3) check("Ifmap_feed_3", 32'(Ifmap_feed_3), 32'(e_f3));
            if (pe_en === 1'b1) begin
                pe_cnt++;
                trip_q.push_back({Ifmap_feed_1, Ifmap_feed_2, Ifmap_feed_3});
                last_pe_cyc = cyc;
            end
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_gap = cyc - last_pe_cyc;
            end
        end
    end

    task automatic tick();
        @(posedge PE_clk); #1;
    endtask

    task automatic wr_flt(input logic [1:0] row, input logic [11:0] data);
        flt_wr = 1; flt_row = row; flt_data = data;
        tick();
        flt_wr = 0;
    endtask

    task automatic send_pixel(input logic [23:0] d, input bit gate);
        logic rdy;
        bit   done = 0;
        if (gate) begin
            while ($urandom_range(1, 0) == 1) begin
                ifc.s_valid = 0;
                tick();
            end
        end
        ifc.s_valid = 1; ifc.s_data = d;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge PE_clk); rdy = ifc.s_ready;
            tick();
            if (rdy) done = 1;
        end
        if (!done) begin
            n_checks++; n_err++;
            $display("FAIL accept_timeout: pixel %0d not accepted within 50 cycles", d);
        end
    endtask

    task automatic run_frame(input bit gate, input int hold_at, input int poke_at, input int abort_after);
        start = 1; tick(); start = 0;
        for (int p = 1; p <= int'(W * H); p++) begin
            if (p == hold_at) begin
                ifc.s_valid = 1; ifc.s_data = 24'(p); ifc.col_hold = 1;
                repeat (3) tick();
                ifc.col_hold = 0;
            end
            if (p == poke_at) begin
                ifc.s_valid = 0; start = 1; flt_wr = 1; flt_row = 2'd0; flt_data = 12'hFFF;
                tick();
                start = 0; flt_wr = 0;
            end
            send_pixel(24'(p), gate);
            if (p == abort_after) begin
                ifc.s_valid = 0; rst_n = 0;
                tick();
                rst_n = 1;
                return;
            end
        end
        ifc.s_valid = 0;
        repeat (4) tick();
    endtask

    task automatic clear_stats();
        pe_cnt = 0; fd_cnt = 0; fd_gap = -1; trip_q.delete();
    endtask

    task automatic frame_checks(input string tag);
        logic [71:0] first_t, last_t;
        first_t = PAD ? {24'd0, 24'd0, 24'd1} : {24'd1, 24'd5, 24'd9};
        last_t  = {24'd4, 24'd8, 24'd12};
        check({tag, "_pe_count"}, 32'(pe_cnt), PAD ? 32'd12 : 32'd4);
        check({tag, "_fd_count"}, 32'(fd_cnt), 32'd1);
        check({tag, "_fd_gap"}, 32'(fd_gap), 32'd1);
        if (trip_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL %s_triples: got none expected %0d", tag, PAD ? 12 : 4);
        end else begin
            check({tag, "_first_f1"}, 32'(trip_q[0][71:48]), 32'(first_t[71:48]));
            check({tag, "_first_f2"}, 32'(trip_q[0][47:24]), 32'(first_t[47:24]));
            check({tag, "_first_f3"}, 32'(trip_q[0][23:0]),  32'(first_t[23:0]));
            check({tag, "_last"}, 32'(trip_q[trip_q.size()-1] == last_t), 32'd1);
        end
        check({tag, "_flt1"}, 32'(Filtr_feed_1), 32'h123);
        check({tag, "_flt2"}, 32'(Filtr_feed_2), 32'h456);
        check({tag, "_flt3"}, 32'(Filtr_feed_3), 32'h789);
    endtask

    initial begin
        ifc.s_valid = 0; ifc.s_data = '0; ifc.col_hold = 0;
        @(posedge PE_clk); #1;
        chk_en = 1;
        repeat (2) tick();
        check("rst_feed_1", 32'(Ifmap_feed_1), 32'd0);
        check("rst_pe_en", 32'(pe_en), 32'd0);
        check("rst_s_ready", 32'(ifc.s_ready), 32'd0);
        rst_n = 1;
        tick();

        // Scenario 1: plain frame
        wr_flt(2'd0, 12'h123); wr_flt(2'd1, 12'h456); wr_flt(2'd2, 12'h789);
        clear_stats(); run_frame(0, 0, 0, 0); frame_checks("s1");
        check("s1_busy_after", 32'(busy), 32'd0);

        // Scenario 2: three-cycle stall at pixel 10
        clear_stats(); run_frame(0, 10, 0, 0); frame_checks("s2");

        // Scenario 3: randomly gated valid
        clear_stats(); run_frame(1, 0, 0, 0); frame_checks("s3");

        // Scenario 4: filter write and start mid-frame, then ignored row 3 write
        clear_stats(); run_frame(0, 0, 10, 0); frame_checks("s4");
        wr_flt(2'd3, 12'hABC); tick();
        check("s4_row3_flt1", 32'(Filtr_feed_1), 32'h123);
        check("s4_row3_flt3", 32'(Filtr_feed_3), 32'h789);

        // Scenario 5: reset after pixel 7, then a fresh frame
        clear_stats(); run_frame(0, 0, 0, 7);
        check("s5_rst_f1", 32'(Ifmap_feed_1), 32'd0);
        check("s5_rst_f3", 32'(Ifmap_feed_3), 32'd0);
        check("s5_rst_flt1", 32'(Filtr_feed_1), 32'd0);
        check("s5_rst_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        check("s5_no_fd", 32'(fd_cnt), 32'd0);
        wr_flt(2'd0, 12'h123); wr_flt(2'd1, 12'h456); wr_flt(2'd2, 12'h789);
        clear_stats(); run_frame(0, 0, 0, 0); frame_checks("s5");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
